// File: rtl/am_pkg.sv
// am_pkg: sequencer state encoding and widths/defaults shared with the AM datapath.
package am_pkg;
  localparam int WIDTH = 13;
  localparam int PHASE_WIDTH = 32;
  localparam int BURST_WIDTH = 16;
  localparam logic [31:0] DEFAULT_STEP = 32'h33333333;
  typedef enum logic [1:0] {IDLE, ON, OFF} seq_state_t;
endpackage

// File: rtl/am_burst_sequencer_if.sv
// am_burst_sequencer_if: configuration valid/ready channel into the burst sequencer.
interface am_burst_sequencer_if #(
  parameter int WIDTH = am_pkg::WIDTH,
  parameter int PHASE_WIDTH = am_pkg::PHASE_WIDTH,
  parameter int BURST_WIDTH = am_pkg::BURST_WIDTH
);
  logic cfg_valid;
  logic cfg_ready;
  logic [PHASE_WIDTH-1:0] cfg_freq_step;
  logic [WIDTH-1:0] cfg_distance;
  logic [BURST_WIDTH-1:0] cfg_on_periods;
  logic [BURST_WIDTH-1:0] cfg_off_cycles;
  logic [BURST_WIDTH-1:0] cfg_bursts;
  modport master (output cfg_valid, cfg_freq_step, cfg_distance, cfg_on_periods, cfg_off_cycles, cfg_bursts, input cfg_ready);
  modport slave (input cfg_valid, cfg_freq_step, cfg_distance, cfg_on_periods, cfg_off_cycles, cfg_bursts, output cfg_ready);
endinterface

// File: rtl/phase_mirror.sv
// phase_mirror: shadow phase accumulator; wrap is the carry-out of the current add.
module phase_mirror #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] step,
  output logic         wrap
);
  logic [W-1:0] phase;
  logic [W:0] sum;
  assign sum = {1'b0, phase} + {1'b0, step};
  assign wrap = en & sum[W];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) phase <= '0;
    else if (clr) phase <= '0;
    else if (en) phase <= sum[W-1:0];
endmodule

// File: rtl/am_burst_sequencer.sv
// am_burst_sequencer: burst on/off sequencing of the AM datapath with wrap-aligned config updates.
module am_burst_sequencer #(
  parameter int WIDTH = am_pkg::WIDTH,
  parameter int PHASE_WIDTH = am_pkg::PHASE_WIDTH,
  parameter int BURST_WIDTH = am_pkg::BURST_WIDTH,
  parameter logic [PHASE_WIDTH-1:0] DEFAULT_STEP = am_pkg::DEFAULT_STEP
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   stop,
  am_burst_sequencer_if.slave    cfg,
  output logic                   dac_enable,
  output logic [PHASE_WIDTH-1:0] dac_freq_step,
  output logic [WIDTH-1:0]       dac_distance,
  output logic                   busy,
  output logic                   done
);
  import am_pkg::*;
  localparam logic [BURST_WIDTH-1:0] ONE = BURST_WIDTH'(1);
  seq_state_t state, n_state;
  logic [BURST_WIDTH-1:0] act_on, act_off, act_bursts, pend_on, pend_off, pend_bursts;
  logic [BURST_WIDTH-1:0] eff_on, eff_off, eff_bursts, reload;
  logic [BURST_WIDTH-1:0] period_cnt, burst_cnt, off_cnt, n_period, n_burst, n_off;
  logic [PHASE_WIDTH-1:0] pend_step;
  logic [WIDTH-1:0] pend_dist;
  logic pending, stop_req, off_first, n_stop_req, n_done, wrap, apply, accept, go;
  phase_mirror #(.W(PHASE_WIDTH)) u_mirror (
    .clk(clk), .reset_n(reset_n), .en(dac_enable), .clr(go), .step(dac_freq_step), .wrap(wrap)
  );
  assign accept = cfg.cfg_valid && cfg.cfg_ready;
  assign apply = pending && (state == IDLE || (state == ON && wrap) || (state == OFF && off_first));
  // a config applied this cycle already governs any reload made in the same cycle
  assign eff_on = apply ? pend_on : act_on;
  assign eff_off = apply ? pend_off : act_off;
  assign eff_bursts = apply ? pend_bursts : act_bursts;
  assign reload = (eff_on == '0) ? ONE : eff_on;
  assign go = state == IDLE && start && !stop;
  always_comb begin
    n_state = state;
    n_period = period_cnt;
    n_burst = burst_cnt;
    n_off = off_cnt;
    n_stop_req = stop_req;
    n_done = 1'b0;
    case (state)
      IDLE: if (go) begin
        n_state = ON;
        n_period = reload;
        n_burst = eff_bursts;
      end
      ON: begin
        n_stop_req = stop_req | stop;
        if (wrap) begin
          if (stop_req || stop || (period_cnt == ONE && burst_cnt == ONE)) begin
            n_state = IDLE;
            n_done = 1'b1;
            n_stop_req = 1'b0;
          end else if (period_cnt == ONE) begin
            n_period = reload;
            n_burst = (burst_cnt == '0) ? '0 : burst_cnt - ONE;
            if (eff_off != '0) begin
              n_state = OFF;
              n_off = eff_off;
            end
          end else n_period = period_cnt - ONE;
        end
      end
      OFF: if (stop) begin
        n_state = IDLE;
        n_done = 1'b1;
      end else if (off_cnt == ONE) begin
        n_state = ON;
        n_period = reload;
      end else n_off = off_cnt - ONE;
      default: n_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      period_cnt <= '0;
      burst_cnt <= '0;
      off_cnt <= '0;
      stop_req <= 1'b0;
      off_first <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
      dac_enable <= 1'b0;
      dac_freq_step <= DEFAULT_STEP;
      dac_distance <= '0;
      act_on <= ONE;
      act_off <= '0;
      act_bursts <= '0;
      pend_on <= '0;
      pend_off <= '0;
      pend_bursts <= '0;
      pend_step <= '0;
      pend_dist <= '0;
      pending <= 1'b0;
      cfg.cfg_ready <= 1'b1;
    end else begin
      state <= n_state;
      period_cnt <= n_period;
      burst_cnt <= n_burst;
      off_cnt <= n_off;
      stop_req <= n_stop_req;
      off_first <= n_state == OFF && state != OFF;
      done <= n_done;
      busy <= n_state != IDLE;
      dac_enable <= n_state == ON;
      if (accept) begin
        pend_step <= cfg.cfg_freq_step;
        pend_dist <= cfg.cfg_distance;
        pend_on <= cfg.cfg_on_periods;
        pend_off <= cfg.cfg_off_cycles;
        pend_bursts <= cfg.cfg_bursts;
        pending <= 1'b1;
        cfg.cfg_ready <= 1'b0;
      end
      if (apply) begin
        act_on <= pend_on;
        act_off <= pend_off;
        act_bursts <= pend_bursts;
        dac_freq_step <= pend_step;
        dac_distance <= pend_dist;
        pending <= 1'b0;
        cfg.cfg_ready <= 1'b1;
      end
    end
endmodule
